// File: rtl/param_branch_unit.sv
// Next-PC selection (sequential / jump target / return) with a circular return-address stack.
// Latency: one clk from inputs to pc. No backpressure; pcStall freezes all state.
module param_branch_unit #(
  parameter int unsigned ADDR_SIZE   = 20,
  parameter int unsigned NUM_TARGETS = 4,
  parameter int unsigned RAS_DEPTH   = 8,
  parameter int unsigned PC_INC      = 1,
  parameter int unsigned RESET_PC    = 0,
  localparam int unsigned SEL_W      = $clog2(NUM_TARGETS + 1),
  localparam int unsigned DEPTH_W    = $clog2(RAS_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pcStall,
  input  logic [SEL_W-1:0]                 selWire,
  input  logic [NUM_TARGETS*ADDR_SIZE-1:0] jumpTargets,
  input  logic                             callEn,
  input  logic                             retEn,
  output logic [ADDR_SIZE-1:0]             pc,
  output logic [DEPTH_W-1:0]               rasDepth,
  output logic                             rasEmpty,
  output logic                             rasFull,
  output logic                             rasError
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [ADDR_SIZE-1:0] stack_q [RAS_DEPTH];
  logic [ADDR_SIZE-1:0] stack_d [RAS_DEPTH];
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 err_q, err_d;

  logic [ADDR_SIZE-1:0] pc_inc;
  logic [ADDR_SIZE-1:0] seq_pc;
  logic [PTR_W-1:0]     top_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic                 empty;
  logic                 full;

  assign pc_inc = pc_q + ADDR_SIZE'(PC_INC);
  assign empty  = (depth_q == '0);
  assign full   = (depth_q == DEPTH_W'(RAS_DEPTH));

  // ptr_q is the next free slot; the top sits one below it, wrapping in a ring.
  assign top_idx  = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
  assign ptr_next = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

  // Out-of-range selects fall through to sequential.
  always_comb begin
    seq_pc = pc_inc;
    for (int i = 0; i < int'(NUM_TARGETS); i++) begin
      if (selWire == SEL_W'(i + 1)) seq_pc = jumpTargets[i*ADDR_SIZE +: ADDR_SIZE];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    err_d   = 1'b0;
    stack_d = stack_q;
    if (!pcStall) begin
      pc_d = seq_pc;
      if (retEn && !empty) begin
        pc_d = stack_q[top_idx];
        if (callEn) begin
          stack_d[top_idx] = pc_inc;
        end else begin
          ptr_d   = top_idx;
          depth_d = depth_q - DEPTH_W'(1);
        end
      end else begin
        if (retEn) begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
        // Pushing onto a full ring overwrites the oldest slot.
        if (callEn) begin
          stack_d[ptr_q] = pc_inc;
          ptr_d          = ptr_next;
          if (full) err_d = 1'b1;
          else      depth_d = depth_q + DEPTH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= ADDR_SIZE'(RESET_PC);
      stack_q <= '{default: '0};
      ptr_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stack_q <= stack_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign pc       = pc_q;
  assign rasDepth = depth_q;
  assign rasEmpty = empty;
  assign rasFull  = full;
  assign rasError = err_q;

endmodule

// File: tb/tb_param_branch_unit.sv
// Directed bench for param_branch_unit with ADDR_SIZE=20, NUM_TARGETS=4, RAS_DEPTH=4.
module tb_param_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcStall;
  logic [2:0]  selWire;
  logic [79:0] jumpTargets;
  logic        callEn;
  logic        retEn;
  logic [19:0] pc;
  logic [2:0]  rasDepth;
  logic        rasEmpty;
  logic        rasFull;
  logic        rasError;

  int errors = 0;
  int checks = 0;

  param_branch_unit #(
    .ADDR_SIZE(20), .NUM_TARGETS(4), .RAS_DEPTH(4), .PC_INC(1), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .pcStall(pcStall), .selWire(selWire),
    .jumpTargets(jumpTargets), .callEn(callEn), .retEn(retEn), .pc(pc),
    .rasDepth(rasDepth), .rasEmpty(rasEmpty), .rasFull(rasFull), .rasError(rasError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [19:0] e_pc, input int e_depth,
                             input logic e_err);
    check({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check({tag, ".depth"}, 32'(rasDepth), 32'(e_depth));
    check({tag, ".empty"}, 32'(rasEmpty), 32'(e_depth == 0));
    check({tag, ".full"}, 32'(rasFull), 32'(e_depth == 4));
    check({tag, ".err"}, 32'(rasError), 32'(e_err));
  endtask

  logic [19:0] ret_exp [4] = '{20'h01031, 20'h01021, 20'h01011, 20'h01001};

  initial begin
    reset = 1'b1; pcStall = 1'b0; selWire = 3'd0; jumpTargets = '0;
    callEn = 1'b0; retEn = 1'b0;
    #3;
    check_state("reset_pre_clk", 20'h0, 0, 1'b0);
    selWire = 3'd1; jumpTargets[19:0] = 20'h00abc; callEn = 1'b1;
    step();
    step();
    check_state("reset_held", 20'h0, 0, 1'b0);
    reset = 1'b0; selWire = 3'd0; callEn = 1'b0;
    check("rel.pc", 32'(pc), 32'h0);

    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq.pc", 32'(pc), 32'(i));
    end

    selWire = 3'd2; jumpTargets[39:20] = 20'h00100; callEn = 1'b1;
    step();
    check_state("call1", 20'h00100, 1, 1'b0);
    selWire = 3'd0; callEn = 1'b0; retEn = 1'b1;
    step();
    check_state("ret1", 20'h00004, 0, 1'b0);
    retEn = 1'b0;

    // Five calls through target 2; the fifth overflows and drops the oldest return address.
    selWire = 3'd3; callEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jumpTargets[59:40] = 20'h01000 + 20'(i * 16);
      step();
      check_state("ovf_call", 20'h01000 + 20'(i * 16), (i < 4) ? i + 1 : 4, i == 4);
    end
    callEn = 1'b0; retEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_state("ret_pop", ret_exp[i], 3 - i, 1'b0);
    end
    step();
    check_state("underflow", 20'h01002, 0, 1'b1);
    retEn = 1'b0; selWire = 3'd0;
    step();
    check_state("after_uf", 20'h01003, 0, 1'b0);

    // Out-of-range select behaves as sequential.
    selWire = 3'd7;
    step();
    check("sel_oob.pc", 32'(pc), 32'h01004);

    selWire = 3'd1; jumpTargets[19:0] = 20'hfffff;
    step();
    check("wrap_jump.pc", 32'(pc), 32'hfffff);
    selWire = 3'd0;
    step();
    check("wrap_seq.pc", 32'(pc), 32'h00000);

    selWire = 3'd2; jumpTargets[39:20] = 20'h00200; callEn = 1'b1;
    step();
    step();
    check_state("pre_stall", 20'h00200, 2, 1'b0);
    pcStall = 1'b1; selWire = 3'd3; retEn = 1'b1;
    step();
    check_state("stall", 20'h00200, 2, 1'b0);
    pcStall = 1'b0; callEn = 1'b0;
    step();
    check_state("post_stall_ret", 20'h00201, 1, 1'b0);

    // Simultaneous call and return swaps the top entry.
    callEn = 1'b1;
    step();
    check_state("callret", 20'h00001, 1, 1'b0);
    callEn = 1'b0;
    step();
    check_state("callret_pop", 20'h00202, 0, 1'b0);
    retEn = 1'b0; selWire = 3'd0; callEn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_state("pre_reset", 20'h00205, 3, 1'b0);

    #2;
    reset = 1'b1;
    #1;
    check_state("async_reset", 20'h0, 0, 1'b0);
    reset = 1'b0; callEn = 1'b0;
    step();
    check_state("post_reset_seq", 20'h00001, 0, 1'b0);
    retEn = 1'b1;
    step();
    check_state("post_reset_uf", 20'h00002, 0, 1'b1);
    retEn = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_branch_unit.md
PARAM_BRANCH_UNIT -- requirements
Module: param_branch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 20: PC and target width in bits.
REQ-002 The block SHALL have parameter NUM_TARGETS, default 4: number of jump-target inputs, legal range 1..15.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 8: number of return-address-stack entries, legal range 2..64.
REQ-004 The block SHALL have parameter PC_INC, default 1: sequential PC increment.
REQ-005 The block SHALL have parameter RESET_PC, default 0: PC value held while in reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port pcStall, input, 1 bit: freezes all state when high.
REQ-009 The block SHALL have port selWire, input, $clog2(NUM_TARGETS+1) bits: 0 selects sequential; k in 1..NUM_TARGETS selects target k-1.
REQ-010 The block SHALL have port jumpTargets, input, NUM_TARGETS*ADDR_SIZE bits: a flattened bus in which target i occupies bits [(i+1)*ADDR_SIZE-1 : i*ADDR_SIZE].
REQ-011 The block SHALL have port callEn, input, 1 bit: pushes the return address pc+PC_INC.
REQ-012 The block SHALL have port retEn, input, 1 bit: pops the stack top and uses it as the next PC.
REQ-013 The block SHALL have port pc, output, ADDR_SIZE bits: the registered current PC.
REQ-014 The block SHALL have port rasDepth, output, $clog2(RAS_DEPTH+1) bits: the number of valid stack entries.
REQ-015 The block SHALL have ports rasEmpty and rasFull, outputs, 1 bit each: asserted at depth 0 and at depth RAS_DEPTH respectively.
REQ-016 The block SHALL have port rasError, output, 1 bit: a registered one-cycle pulse on stack overflow or underflow.

Function
REQ-017 pc SHALL update only on a rising clk edge; next-PC priority SHALL be pcStall > retEn > selWire.
REQ-018 With pcStall=1, pc, the stack contents, and rasDepth SHALL hold; callEn and retEn SHALL be ignored; rasError SHALL be 0 next cycle.
REQ-019 With retEn=0, the next pc SHALL be pc+PC_INC for selWire=0 and jumpTargets[selWire-1] for 1<=selWire<=NUM_TARGETS.
REQ-020 A selWire value greater than NUM_TARGETS SHALL be treated as 0.
REQ-021 All PC arithmetic SHALL be modulo 2^ADDR_SIZE, so 0xFFFFF+1 wraps to 0x00000 at ADDR_SIZE=20.
REQ-022 For callEn=1 and retEn=0 with the stack not full, the block SHALL push pc+PC_INC, increment rasDepth, and take the next pc per REQ-019.
REQ-023 For callEn=1 and retEn=0 with the stack full, the block SHALL discard the oldest entry, push the new entry, hold rasDepth at RAS_DEPTH, and pulse rasError.
REQ-024 For retEn=1 and callEn=0 with the stack not empty, the next pc SHALL be the top entry and rasDepth SHALL decrement.
REQ-025 For retEn=1 with the stack empty, the next pc SHALL be pc+PC_INC, rasDepth SHALL stay 0, and rasError SHALL pulse; any callEn in that cycle is handled per REQ-022.
REQ-026 For retEn=1 and callEn=1 with the stack not empty, the next pc SHALL be the old top, the top entry SHALL be replaced by pc+PC_INC, and rasDepth SHALL be unchanged.
REQ-027 rasEmpty, rasFull, and rasDepth SHALL be consistent with the stack state in the same cycle.
REQ-028 The next-PC latency SHALL be exactly one clock; no combinational path SHALL exist from any input to pc.

Reset
REQ-029 While reset=1, independent of clk: pc=RESET_PC, rasDepth=0, rasEmpty=1, rasFull=0, rasError=0.
REQ-030 Reset asserted mid-operation SHALL clear the stack immediately; stack entry contents after reset are don't-care.
REQ-031 After reset deasserts, the first rising edge SHALL apply REQ-017..REQ-026 normally.

Verification
Bench parameters: ADDR_SIZE=20, NUM_TARGETS=4, RAS_DEPTH=4, PC_INC=1, RESET_PC=0.
REQ-032 Release reset; drive selWire=0 for 3 edges -> pc sequence 0,1,2,3.
REQ-033 At pc=3, drive selWire=2, jumpTargets[1]=0x00100, callEn=1 -> pc=0x00100, rasDepth=1; next cycle retEn=1 -> pc=4, rasDepth=0, rasEmpty=1.
REQ-034 Issue 5 consecutive calls -> rasError=1 for one cycle on the 5th, rasDepth=4, rasFull=1; 4 returns yield the last 4 return addresses newest-first; a 5th return -> rasError pulse and pc=pc+1.
REQ-035 Drive selWire=1 with jumpTargets[0]=0xFFFFF, then selWire=0 -> pc=0xFFFFF, then 0x00000.
REQ-036 Drive pcStall=1 together with selWire=3, callEn=1, retEn=1 -> pc and rasDepth unchanged, rasError=0.
REQ-037 At rasDepth=3, assert reset between clock edges -> pc=0 and rasDepth=0 immediately, before the next clk edge.
